// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Receive end of the pulse-framed serial link. Idle line level is 1. Each
//   frame is a START slot (0), eight data slots sent MSB first, and a STOP
//   slot (1). Symbol slots are BIT_PERIOD cycles apart. Every received byte is
//   offered to a consumer through a valid/ack handshake.
//
// Ports
//   clock        rising-edge clock
//   rst_n        asynchronous reset, active low
//   rx_in        serial line input
//   rx_data      last accepted byte
//   rx_valid     rx_data holds a byte the consumer has not yet taken
//   rx_ack       consumer takes the byte (only meaningful while rx_valid=1)
//   dsr          receiver ready, registered copy of !rx_valid
//   busy         a frame is in progress
//   frame_err    one-cycle pulse: 0 seen between slots, or STOP slot was 0
//   overrun_err  one-cycle pulse: good frame dropped because rx_valid was 1
// -----------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int unsigned DELAY_TIME = 104,
    parameter int unsigned BIT_PERIOD = DELAY_TIME + 2,
    parameter int unsigned CNT_W      = 10
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       dsr,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(BIT_PERIOD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             dsr_q, dsr_d;
    logic             ferr_q, ferr_d;
    logic             oerr_q, oerr_d;
    logic             slot;
    logic             good_frame;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            dsr_q   <= 1'b1;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            dsr_q   <= dsr_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        oerr_d     = 1'b0;
        good_frame = 1'b0;
        slot       = (cnt_q == SLOT_CNT);

        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (slot) begin
                    shift_d = {shift_q[6:0], rx_in};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else if (!rx_in) begin
                    // A 0 between slots aborts the frame; it is not a START.
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (slot) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_in) begin
                        good_frame = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (!rx_in) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // An ack arriving with a completing frame frees the buffer in time
        // for the new byte, so it is loaded instead of overrunning.
        if (good_frame) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end else if (valid_q && rx_ack) begin
            valid_d = 1'b0;
        end

        dsr_d = !valid_d;
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign dsr         = dsr_q;
    assign busy        = (state_q != IDLE);
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//   Directed bench for serial_frame_rx. Frames are driven cycle by cycle as
//   offsets from the START cycle T; slots sit at multiples of 106 and the
//   STOP slot at offset 954, so a good byte is visible at T+955.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

    localparam int BP       = 106;
    localparam int STOP_OFS = 9 * BP;

    logic       clock;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       dsr;
    logic       busy;
    logic       frame_err;
    logic       overrun_err;

    int checks   = 0;
    int errors   = 0;
    int ferr_cnt = 0;
    int oerr_cnt = 0;

    serial_frame_rx #(
        .DELAY_TIME(104),
        .BIT_PERIOD(106),
        .CNT_W     (10)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .dsr        (dsr),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun_err === 1'b1) oerr_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input logic stopbit, input int o);
        logic [7:0] v;
        v = b;
        if (o == 0) return 1'b0;
        if (o == STOP_OFS) return stopbit;
        if ((o % BP) == 0 && (o / BP) >= 1 && (o / BP) <= 8) return v[8 - (o / BP)];
        return 1'b1;
    endfunction

    // Drives frame offsets first..last; 'stray' forces a 0 at that offset,
    // 'ack_at' raises rx_ack for that one offset (-1 disables either).
    task automatic drive_range(input logic [7:0] b, input logic stopbit,
                               input int first, input int last,
                               input int stray, input int ack_at);
        for (int o = first; o <= last; o++) begin
            rx_in  = frame_bit(b, stopbit, o);
            if (o == stray) rx_in = 1'b0;
            rx_ack = (o == ack_at);
            tick();
        end
        rx_in  = 1'b1;
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_in  = 1'b1;
        rx_ack = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        rx_in  = 1'b1;
        rx_ack = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_dsr", 32'(dsr), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 1: 0xA5, valid exactly at T+955
        drive_range(8'hA5, 1'b1, 0, STOP_OFS - 1, -1, -1);
        check("t1_busy_stop", 32'(busy), 32'd1);
        check("t1_valid_early", 32'(rx_valid), 32'd0);
        drive_range(8'hA5, 1'b1, STOP_OFS, STOP_OFS, -1, -1);
        check("t1_valid", 32'(rx_valid), 32'd1);
        check("t1_data", 32'(rx_data), 32'hA5);
        check("t1_dsr", 32'(dsr), 32'd0);
        check("t1_busy_done", 32'(busy), 32'd0);
        rx_ack = 1'b1;
        tick();
        check("t1_ack_clear", 32'(rx_valid), 32'd0);
        check("t1_ack_dsr", 32'(dsr), 32'd1);
        tick();
        check("t1_ack_ignored", 32'(rx_valid), 32'd0);
        idle(3);

        // 2: 0xFF then 0x00 back-to-back, ack early in the second frame
        drive_range(8'hFF, 1'b1, 0, STOP_OFS, -1, -1);
        check("t2_valid_ff", 32'(rx_valid), 32'd1);
        check("t2_data_ff", 32'(rx_data), 32'hFF);
        drive_range(8'h00, 1'b1, 0, STOP_OFS, -1, 5);
        check("t2_valid_00", 32'(rx_valid), 32'd1);
        check("t2_data_00", 32'(rx_data), 32'h00);
        check("t2_ferr_cnt", 32'(ferr_cnt), 32'd0);
        check("t2_oerr_cnt", 32'(oerr_cnt), 32'd0);

        // 3: stray 0 at T+50 while 0x00 is still unconsumed
        drive_range(8'h55, 1'b1, 0, 50, 50, -1);
        check("t3_ferr_pulse", 32'(frame_err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_valid_kept", 32'(rx_valid), 32'd1);
        check("t3_data_kept", 32'(rx_data), 32'h00);
        tick();
        check("t3_ferr_drop", 32'(frame_err), 32'd0);
        idle(20);
        check("t3_still_idle", 32'(busy), 32'd0);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        check("t3_ack_clear", 32'(rx_valid), 32'd0);

        // 4: bad STOP, then a good 0x3C
        drive_range(8'hC3, 1'b0, 0, STOP_OFS, -1, -1);
        check("t4_ferr_pulse", 32'(frame_err), 32'd1);
        check("t4_no_valid", 32'(rx_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        idle(4);
        drive_range(8'h3C, 1'b1, 0, STOP_OFS, -1, -1);
        check("t4_valid_3c", 32'(rx_valid), 32'd1);
        check("t4_data_3c", 32'(rx_data), 32'h3C);
        check("t4_ferr_cnt", 32'(ferr_cnt), 32'd2);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        idle(3);

        // 5: overrun, then ack coinciding with the STOP slot
        drive_range(8'h11, 1'b1, 0, STOP_OFS, -1, -1);
        drive_range(8'h22, 1'b1, 0, STOP_OFS, -1, -1);
        check("t5_data_kept", 32'(rx_data), 32'h11);
        check("t5_valid", 32'(rx_valid), 32'd1);
        check("t5_oerr_pulse", 32'(overrun_err), 32'd1);
        tick();
        check("t5_oerr_drop", 32'(overrun_err), 32'd0);
        check("t5_oerr_cnt", 32'(oerr_cnt), 32'd1);
        drive_range(8'h22, 1'b1, 0, STOP_OFS, -1, STOP_OFS);
        check("t5_data_22", 32'(rx_data), 32'h22);
        check("t5_valid_22", 32'(rx_valid), 32'd1);
        check("t5_no_oerr", 32'(overrun_err), 32'd0);
        check("t5_oerr_cnt2", 32'(oerr_cnt), 32'd1);

        // 6: asynchronous reset at T+400 with 0x22 still held
        drive_range(8'h5A, 1'b1, 0, 399, -1, -1);
        check("t6_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data", 32'(rx_data), 32'h00);
        check("t6_rst_valid", 32'(rx_valid), 32'd0);
        check("t6_rst_dsr", 32'(dsr), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ferr", 32'(frame_err), 32'd0);
        check("t6_rst_oerr", 32'(overrun_err), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(5);
        drive_range(8'h81, 1'b1, 0, STOP_OFS, -1, -1);
        check("t6_valid_81", 32'(rx_valid), 32'd1);
        check("t6_data_81", 32'(rx_data), 32'h81);
        check("t6_ferr_cnt", 32'(ferr_cnt), 32'd2);
        check("t6_oerr_cnt", 32'(oerr_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
